// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and counter sizing.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_cla.sv
// Carry-lookahead subtractor: diff = a - b computed as a + ~b + 1; borrow set when a < b.
module sub_cla #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry expanded directly from generate/propagate terms and the +1 carry-in.
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b1;
    c[0] = 1'b1;
    for (int i = 1; i <= int'(WIDTH); i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i] = acc | pp;
    end
  end

  assign diff   = p ^ c[WIDTH-1:0];
  assign borrow = ~c[WIDTH];

endmodule

// File: rtl/seq_div_8bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_div_8bit
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = clog2(DATA_WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [W-1:0]     dvd;
  logic [W-1:0]     dsr;
  logic [W-1:0]     rem;
  logic [CNT_W-1:0] cnt;

  logic             accept_c;
  logic             zero_dsr_c;
  logic [W:0]       trial_a;
  logic [W:0]       trial_b;
  logic [W:0]       trial_diff;
  logic             trial_borrow;
  logic             q_bit;
  logic [W-1:0]     rem_nxt;
  logic [W-1:0]     dvd_nxt;

  assign accept_c   = start && (state != ST_CALC);
  assign zero_dsr_c = (divisor == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a start in DONE is taken directly so back-to-back runs have no gap.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = zero_dsr_c ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: begin
        if (start) state_nxt = zero_dsr_c ? ST_DONE : ST_CALC;
        else       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status decoded straight from the state flops.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state == ST_CALC);
    done = (state == ST_DONE);
  end

  sub_cla #(
    .WIDTH (W + 1)
  ) u_sub (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  // The partial remainder stays below the divisor, so a fitting trial never sets its top bit;
  // folding that bit into the decision keeps the step self-consistent.
  always_comb begin
    trial_a = {rem, dvd[W-1]};
    trial_b = {1'b0, dsr};
    q_bit   = ~(trial_borrow | trial_diff[W]);
    rem_nxt = q_bit ? trial_diff[W-1:0] : trial_a[W-1:0];
    dvd_nxt = {dvd[W-2:0], q_bit};
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_c) begin
      if (zero_dsr_c) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        dvd         <= dividend;
        dsr         <= divisor;
        rem         <= '0;
        cnt         <= CNT_W'(W - 1);
        div_by_zero <= 1'b0;
      end
    end else if (state == ST_CALC) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        quotient  <= dvd_nxt;
        remainder <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_8bit.sv
// Self-checking bench for seq_div_8bit using an expected-result queue.
module tb_seq_div_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_div_8bit #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Drive one accepted start and queue its reference result; scrambles operands afterwards.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hff; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    sb.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
  endtask

  // Wait (bounded) for done; reports edges waited, busy samples seen and any early output change.
  task automatic wait_done(output int lat, output bit seen, output bit moved, output int nbusy);
    logic [7:0] q0;
    logic [7:0] r0;
    q0 = quotient; r0 = remainder;
    lat = 0; seen = 1'b0; moved = 1'b0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      if (quotient !== q0 || remainder !== r0) moved = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (quotient !== 8'd0)    begin bad++; $display("FAIL reset_q got=%0d want=0", quotient); end
    total++; if (remainder !== 8'd0)   begin bad++; $display("FAIL reset_r got=%0d want=0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_t e; int lat; bit seen; bit moved; int nb;
    issue(8'd200, 8'd7);
    wait_done(lat, seen, moved, nb);
    e = sb.pop_front();
    total++; if (!seen)              begin bad++; $display("FAIL basic_timeout got=none want=done"); end
    total++; if (lat !== 8)          begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
    total++; if (nb !== 8)           begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", nb); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
    total++; if (quotient !== e.q)   begin bad++; $display("FAIL basic_q got=%0d want=%0d", quotient, e.q); end
    total++; if (remainder !== e.r)  begin bad++; $display("FAIL basic_r got=%0d want=%0d", remainder, e.r); end
    total++; if (div_by_zero !== e.dz) begin bad++; $display("FAIL basic_dz got=%b want=%b", div_by_zero, e.dz); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_table();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    exp_t e; int lat; bit seen; bit moved; int nb;
    ta = '{8'd255, 8'd5, 8'd9, 8'd0};
    tb = '{8'd1,   8'd9, 8'd9, 8'd3};
    for (int k = 0; k < 4; k++) begin
      issue(ta[k], tb[k]);
      wait_done(lat, seen, moved, nb);
      e = sb.pop_front();
      total++; if (!seen || lat !== 8)  begin bad++; $display("FAIL table%0d_latency got=%0d want=8", k, lat); end
      total++; if (quotient !== e.q)    begin bad++; $display("FAIL table%0d_q got=%0d want=%0d", k, quotient, e.q); end
      total++; if (remainder !== e.r)   begin bad++; $display("FAIL table%0d_r got=%0d want=%0d", k, remainder, e.r); end
      total++; if (div_by_zero !== e.dz) begin bad++; $display("FAIL table%0d_dz got=%b want=%b", k, div_by_zero, e.dz); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    exp_t e; int lat; bit seen; bit moved; int nb;
    issue(8'd77, 8'd0);
    wait_done(lat, seen, moved, nb);
    e = sb.pop_front();
    total++; if (!seen || lat !== 0)  begin bad++; $display("FAIL dz_latency got=%0d want=0", lat); end
    total++; if (quotient !== e.q)    begin bad++; $display("FAIL dz_q got=%0d want=%0d", quotient, e.q); end
    total++; if (remainder !== e.r)   begin bad++; $display("FAIL dz_r got=%0d want=%0d", remainder, e.r); end
    total++; if (div_by_zero !== e.dz) begin bad++; $display("FAIL dz_flag got=%b want=%b", div_by_zero, e.dz); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL dz_done_width got=%b want=0", done); end
    issue(8'd10, 8'd3);
    wait_done(lat, seen, moved, nb);
    e = sb.pop_front();
    total++; if (!seen || lat !== 8)  begin bad++; $display("FAIL dzclr_latency got=%0d want=8", lat); end
    total++; if (quotient !== e.q)    begin bad++; $display("FAIL dzclr_q got=%0d want=%0d", quotient, e.q); end
    total++; if (remainder !== e.r)   begin bad++; $display("FAIL dzclr_r got=%0d want=%0d", remainder, e.r); end
    total++; if (div_by_zero !== e.dz) begin bad++; $display("FAIL dzclr_flag got=%b want=%b", div_by_zero, e.dz); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit seen; bit moved; int nb;
    issue(8'd100, 8'd3);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, seen, moved, nb);
    e = sb.pop_front();
    total++; if (!seen || lat !== 5)  begin bad++; $display("FAIL ignore_latency got=%0d want=5", lat); end
    total++; if (moved)               begin bad++; $display("FAIL ignore_stable got=changed want=stable"); end
    total++; if (quotient !== e.q)    begin bad++; $display("FAIL ignore_q got=%0d want=%0d", quotient, e.q); end
    total++; if (remainder !== e.r)   begin bad++; $display("FAIL ignore_r got=%0d want=%0d", remainder, e.r); end
    issue(8'd50, 8'd5);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got=done%b_busy%b want=done0_busy1", done, busy);
    end
    wait_done(lat, seen, moved, nb);
    e = sb.pop_front();
    total++; if (!seen || lat !== 8)  begin bad++; $display("FAIL b2b_latency got=%0d want=8", lat); end
    total++; if (quotient !== e.q)    begin bad++; $display("FAIL b2b_q got=%0d want=%0d", quotient, e.q); end
    total++; if (remainder !== e.r)   begin bad++; $display("FAIL b2b_r got=%0d want=%0d", remainder, e.r); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; bit seen; bit moved; int nb;
    issue(8'd180, 8'd11);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got=busy%b_done%b want=busy0_done0", busy, done);
    end
    total++; if (quotient !== 8'd0)    begin bad++; $display("FAIL rstmid_q got=%0d want=0", quotient); end
    total++; if (remainder !== 8'd0)   begin bad++; $display("FAIL rstmid_r got=%0d want=0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rstmid_dz got=%b want=0", div_by_zero); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'd180, 8'd11);
    wait_done(lat, seen, moved, nb);
    e = sb.pop_front();
    total++; if (!seen || lat !== 8)  begin bad++; $display("FAIL rstrec_latency got=%0d want=8", lat); end
    total++; if (quotient !== e.q)    begin bad++; $display("FAIL rstrec_q got=%0d want=%0d", quotient, e.q); end
    total++; if (remainder !== e.r)   begin bad++; $display("FAIL rstrec_r got=%0d want=%0d", remainder, e.r); end
  endtask

  task automatic test_random();
    exp_t e; int lat; bit seen; bit moved; int nb; int gap; int want_lat;
    logic [7:0] a; logic [7:0] b;
    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      want_lat = (b == 8'd0) ? 0 : 8;
      issue(a, b);
      wait_done(lat, seen, moved, nb);
      e = sb.pop_front();
      total++; if (!seen || lat !== want_lat) begin
        bad++; $display("FAIL rand%0d_latency %0d/%0d got=%0d want=%0d", n, a, b, lat, want_lat);
      end
      total++; if (moved) begin bad++; $display("FAIL rand%0d_stable got=changed want=stable", n); end
      total++; if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        bad++; $display("FAIL rand%0d_result %0d/%0d got=%0d,%0d,%b want=%0d,%0d,%b",
                        n, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rand%0d_done_width got=%b want=0", n, done); end
        repeat (gap - 1) begin @(posedge clk); #1; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_table();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
